// File: rtl/line_length.sv
// Sliding-window line-length extractor: LL = sum of |x[n]-x[n-1]| over the last 2^WIN_LOG2 diffs.
// Optional output decimation is enabled by defining LL_DECIM_EN.
module line_length #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 8,
  parameter int LL_WIDTH   = 25,
  parameter int DEC_LOG2   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic                         clear,
  output logic signed [LL_WIDTH-1:0]   ll_out,
  output logic                         ll_ready
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_LAST = (WIN_LOG2 + 1)'(WIN - 1);

  if (LL_WIDTH < DATA_WIDTH + WIN_LOG2 + 1 || WIN_LOG2 < 1 || DEC_LOG2 < 1) begin : g_bad_params
    $error("line_length: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_RUN
  } state_t;

  state_t                         state_q, state_d;
  logic [WIN_LOG2-1:0]            wr_ptr_q, wr_ptr_d;
  logic [WIN_LOG2:0]              fill_cnt_q, fill_cnt_d;
  logic signed [DATA_WIDTH-1:0]   x_prev_q, x_prev_d;
  logic [LL_WIDTH-1:0]            acc_q, acc_d;

  logic                           s1_vld_q, s1_vld_d;
  logic                           s1_emit_q, s1_emit_d;
  logic [DATA_WIDTH-1:0]          s1_diff_q, s1_diff_d;
  logic [DATA_WIDTH-1:0]          s1_old_q, s1_old_d;
  logic [WIN_LOG2-1:0]            s1_ptr_q, s1_ptr_d;

  logic signed [LL_WIDTH-1:0]     ll_out_q, ll_out_d;
  logic                           ll_ready_q, ll_ready_d;

  logic [DATA_WIDTH-1:0]          diff_mem_q [WIN];
  logic                           mem_we;

`ifdef LL_DECIM_EN
  logic [DEC_LOG2-1:0]            dec_cnt_q, dec_cnt_d;
`endif

  logic signed [DATA_WIDTH:0]     delta;
  logic [DATA_WIDTH:0]            neg_delta;
  logic [DATA_WIDTH-1:0]          abs_delta;
  logic [LL_WIDTH-1:0]            acc_next;
  logic                           run_sample;

  // One extra bit keeps the difference exact across the full signed range.
  always_comb begin
    delta     = {din[DATA_WIDTH-1], din} - {x_prev_q[DATA_WIDTH-1], x_prev_q};
    neg_delta = -delta;
    abs_delta = delta[DATA_WIDTH] ? neg_delta[DATA_WIDTH-1:0] : delta[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    x_prev_d   = x_prev_q;
    s1_vld_d   = 1'b0;
    s1_emit_d  = 1'b0;
    s1_diff_d  = abs_delta;
    s1_old_d   = diff_mem_q[wr_ptr_q];
    s1_ptr_d   = wr_ptr_q;
    run_sample = 1'b0;
`ifdef LL_DECIM_EN
    dec_cnt_d  = dec_cnt_q;
`endif

    if (clear) begin
      state_d    = ST_EMPTY;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      x_prev_d   = '0;
`ifdef LL_DECIM_EN
      dec_cnt_d  = '0;
`endif
    end else if (din_valid) begin
      s1_vld_d = 1'b1;
      x_prev_d = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
      unique case (state_q)
        ST_EMPTY: begin
          s1_diff_d  = '0;
          s1_old_d   = '0;
          fill_cnt_d = (WIN_LOG2 + 1)'(1);
          state_d    = ST_FILL;
        end
        ST_FILL: begin
          // Buffer is never reset, so stale slots must be masked until the window is full.
          s1_old_d   = '0;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == FILL_LAST) begin
            state_d    = ST_RUN;
            run_sample = 1'b1;
          end
        end
        ST_RUN: run_sample = 1'b1;
        default: state_d = ST_EMPTY;
      endcase
`ifdef LL_DECIM_EN
      if (run_sample) begin
        s1_emit_d = (dec_cnt_q == '0);
        dec_cnt_d = dec_cnt_q + 1'b1;
      end
`else
      s1_emit_d = run_sample;
`endif
    end
  end

  always_comb begin
    acc_d      = acc_q;
    ll_ready_d = 1'b0;
    ll_out_d   = ll_out_q;
    acc_next   = acc_q + {{(LL_WIDTH - DATA_WIDTH){1'b0}}, s1_diff_q}
                       - {{(LL_WIDTH - DATA_WIDTH){1'b0}}, s1_old_q};
    mem_we     = s1_vld_q && !clear;

    if (clear) begin
      acc_d = '0;
    end else if (s1_vld_q) begin
      acc_d = acc_next;
      if (s1_emit_q) begin
        ll_ready_d = 1'b1;
        ll_out_d   = $signed(acc_next);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      x_prev_q   <= '0;
      acc_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_diff_q  <= '0;
      s1_old_q   <= '0;
      s1_ptr_q   <= '0;
      ll_out_q   <= '0;
      ll_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      x_prev_q   <= x_prev_d;
      acc_q      <= acc_d;
      s1_vld_q   <= s1_vld_d;
      s1_emit_q  <= s1_emit_d;
      s1_diff_q  <= s1_diff_d;
      s1_old_q   <= s1_old_d;
      s1_ptr_q   <= s1_ptr_d;
      ll_out_q   <= ll_out_d;
      ll_ready_q <= ll_ready_d;
    end
  end

`ifdef LL_DECIM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_cnt_q <= '0;
    else        dec_cnt_q <= dec_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) diff_mem_q[s1_ptr_q] <= s1_diff_q;
  end

  assign ll_out   = ll_out_q;
  assign ll_ready = ll_ready_q;

endmodule
